// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: shared state/cause encodings and default constants for the sequencer
// Contents: seq_state_e (FSM states), halt_cause_e (reason reported on halted),
// default RESET_PC / PC_STEP / TIMEOUT_CYCLES values used by core_sequencer.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        HC_NONE     = 2'd0,
        HC_HALT_REQ = 2'd1,
        HC_ILLEGAL  = 2'd2,
        HC_TIMEOUT  = 2'd3
    } halt_cause_e;

    localparam logic [31:0] DEF_RESET_PC       = 32'h0;
    localparam int          DEF_PC_STEP        = 1;
    localparam int          DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts consecutive FETCH cycles without an acknowledge
// Ports: clk, reset_n (sync, active-low), clear (hold count at zero),
// inc (one more cycle without ack), at_limit (current cycle is the LIMIT-th waiting cycle).
// Instantiated by core_sequencer only when SEQ_IMEM_TIMEOUT_EN is defined.
module seq_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clear)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + W'(1);
    end

    // cnt holds the waiting cycles already elapsed, so LIMIT-1 marks the last allowed one
    assign at_limit = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM owning pc, ir and the imem handshake
// Ports: clk, reset_n (sync, active-low); run / halt_req issue control;
// imem_req/imem_addr/imem_ack/imem_rdata fetch handshake; ir/ir_valid instruction register;
// illegal, wb_needed, redirect_valid/redirect_pc from decode/execute; ex_en/rf_we datapath strobes;
// pc, halted, halt_cause, retire_count status.
// Option: define SEQ_IMEM_TIMEOUT_EN to halt (cause 3) after TIMEOUT_CYCLES fetch cycles without ack.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = XLEN'(DEF_RESET_PC),
    parameter int              PC_STEP        = DEF_PC_STEP,
    parameter int              TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            ir_valid,
    input  logic            illegal,
    input  logic            wb_needed,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ex_en,
    output logic            rf_we,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic [1:0]      halt_cause,
    output logic [31:0]     retire_count
);

    seq_state_e      state, state_nx;
    halt_cause_e     cause, cause_nx;
    logic [XLEN-1:0] next_pc;
    logic            timeout;

`ifdef SEQ_IMEM_TIMEOUT_EN
    seq_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != FETCH),
        .inc     (state == FETCH && !imem_ack),
        .at_limit(timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cause_nx = cause;
        case (state)
            IDLE:      state_nx = run ? FETCH : IDLE;
            FETCH: begin
                // an ack on the limit cycle wins over the timeout
                if (imem_ack) begin
                    state_nx = DECODE;
                end else if (timeout) begin
                    state_nx = HALT;
                    cause_nx = HC_TIMEOUT;
                end
            end
            DECODE: begin
                state_nx = illegal ? HALT : EXECUTE;
                cause_nx = illegal ? HC_ILLEGAL : cause;
            end
            EXECUTE:   state_nx = WRITEBACK;
            WRITEBACK: begin
                state_nx = halt_req ? HALT : (run ? FETCH : IDLE);
                cause_nx = halt_req ? HC_HALT_REQ : cause;
            end
            HALT:      state_nx = HALT;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cause        <= HC_NONE;
            pc           <= RESET_PC;
            next_pc      <= RESET_PC;
            ir           <= '0;
            ir_valid     <= 1'b0;
            retire_count <= '0;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
            if (state == FETCH && imem_ack) begin
                ir       <= imem_rdata;
                ir_valid <= 1'b1;
            end
            if (state == EXECUTE)
                next_pc <= redirect_valid ? redirect_pc : pc + XLEN'(PC_STEP);
            if (state == WRITEBACK) begin
                pc           <= next_pc;
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign ex_en      = (state == EXECUTE);
    assign rf_we      = (state == WRITEBACK) && wb_needed;
    assign halted     = (state == HALT);
    assign halt_cause = cause;

endmodule
